// File: rtl/p4_router_ing_arbiter.sv
// p4_router_ing_arbiter: packet-level round-robin merge of per-port AXIS ingress streams.
// Define P4_ROUTER_ING_ARB_PKT_CNT_EN to add per-port output packet counters.
module p4_router_ing_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_BYTES    = 8,
  parameter int PORT_ID_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_PORTS-1:0]              port_enable,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  output logic [NUM_PORTS-1:0]              in_tready,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0] in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]   in_tkeep,
  input  logic [NUM_PORTS-1:0]              in_tlast,
  output logic                              out_tvalid,
  input  logic                              out_tready,
  output logic [DATA_BYTES*8-1:0]           out_tdata,
  output logic [DATA_BYTES-1:0]             out_tkeep,
  output logic                              out_tlast,
  output logic [PORT_ID_WIDTH-1:0]          out_tuser,
  output logic                              out_sof
`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]           pkt_cnt,
  input  logic [NUM_PORTS-1:0]              pkt_cnt_clear
`endif
);
  localparam int DW = DATA_BYTES * 8;
  typedef enum logic {IDLE, XFER} state_t;
  state_t                   r_state, w_state_nxt;
  logic [PORT_ID_WIDTH-1:0] r_grant, r_last_grant, w_sel;
  logic                     r_first, r_tvalid, r_tlast, r_sof;
  logic [DW-1:0]            r_tdata, w_src_data;
  logic [DATA_BYTES-1:0]    r_tkeep, w_src_keep;
  logic [PORT_ID_WIDTH-1:0] r_tuser;
  logic [NUM_PORTS-1:0]     w_req;
  logic                     w_src_vld, w_src_last, w_room, w_xfer, w_hs, w_arb;
  int                       w_best;
  always_comb begin
    w_req      = in_tvalid & port_enable;
    w_best     = NUM_PORTS;
    w_sel      = '0;
    w_src_vld  = 1'b0;
    w_src_data = '0;
    w_src_keep = '0;
    w_src_last = 1'b0;
    in_tready  = '0;
    w_room     = out_tready | ~r_tvalid;
    w_xfer     = r_state == XFER;
    // circular distance from last_grant+1; smallest distance wins
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_req[i] && ((i > int'(r_last_grant)) ? i - int'(r_last_grant) - 1
                                                 : i + NUM_PORTS - int'(r_last_grant) - 1) < w_best) begin
        w_best = (i > int'(r_last_grant)) ? i - int'(r_last_grant) - 1
                                          : i + NUM_PORTS - int'(r_last_grant) - 1;
        w_sel  = PORT_ID_WIDTH'(i);
      end
      if (r_grant == PORT_ID_WIDTH'(i)) begin
        w_src_vld    = in_tvalid[i];
        w_src_data   = in_tdata[i*DW +: DW];
        w_src_keep   = in_tkeep[i*DATA_BYTES +: DATA_BYTES];
        w_src_last   = in_tlast[i];
        in_tready[i] = w_xfer & w_room;
      end
    end
    w_hs        = w_xfer & w_src_vld & w_room;
    w_arb       = (r_state == IDLE) & (|w_req) & w_room;
    w_state_nxt = w_arb ? XFER : (w_hs & w_src_last) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      r_first      <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tlast      <= 1'b0;
      r_tuser      <= '0;
      r_sof        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_first      <= 1'b1;
      end
      if (w_hs) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_src_data;
        r_tkeep  <= w_src_keep;
        r_tlast  <= w_src_last;
        r_tuser  <= r_grant;
        r_sof    <= r_first;
        r_first  <= 1'b0;
      end else if (out_tready) begin
        r_tvalid <= 1'b0;
        r_sof    <= 1'b0;
      end
    end
  end
  assign out_tvalid = r_tvalid;
  assign out_tdata  = r_tdata;
  assign out_tkeep  = r_tkeep;
  assign out_tlast  = r_tlast;
  assign out_tuser  = r_tuser;
  assign out_sof    = r_sof;
`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_cnt <= '0;
      else if (pkt_cnt_clear[g]) r_cnt <= '0;
      else if (r_tvalid && out_tready && r_tlast && r_tuser == PORT_ID_WIDTH'(g) && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
    end
    assign pkt_cnt[g*32 +: 32] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_p4_router_ing_arbiter.sv
// tb_p4_router_ing_arbiter: vector table, directed sequences and randomized traffic against a packet-order model.
module tb_p4_router_ing_arbiter;
  localparam int N = 4, DB = 8, PW = 5, DW = 64;
  logic clk = 1'b0, resetn = 1'b0;
  logic [N-1:0] port_enable = '0, in_tvalid = '0, in_tready, in_tlast = '0;
  logic [N*DW-1:0] in_tdata = '0;
  logic [N*DB-1:0] in_tkeep = '0;
  logic out_tvalid, out_tready = 1'b0, out_tlast, out_sof;
  logic [DW-1:0] out_tdata;
  logic [DB-1:0] out_tkeep;
  logic [PW-1:0] out_tuser;
`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
  logic [N*32-1:0] pkt_cnt;
  logic [N-1:0] pkt_cnt_clear = '0;
`endif
  always #5 clk = ~clk;

  p4_router_ing_arbiter #(.NUM_PORTS(N), .DATA_BYTES(DB), .PORT_ID_WIDTH(PW)) dut (
    .clk(clk), .resetn(resetn), .port_enable(port_enable), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tuser(out_tuser), .out_sof(out_sof)
`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt), .pkt_cnt_clear(pkt_cnt_clear)
`endif
  );

  typedef struct packed {logic [DW-1:0] data; logic [DB-1:0] keep; logic last;} beat_t;
  typedef struct packed {
    logic vld; logic [DW-1:0] d; logic lst; logic ordy;
    logic e_ov; logic [N-1:0] e_rdy; logic [DW-1:0] e_d; logic e_sof; logic e_lst; logic [PW-1:0] e_usr;
  } vec_t;
  beat_t q_in[N][$];
  beat_t q_ref[N][$];
  logic [N-1:0] hold, mid;
  int hs_cnt[N];
  int errors = 0, checks = 0;
  int cur, last_served, n_out, gap, rdy_ph, pkts_p0;
  int ord[$];
  bit gaps, rnd_rdy, chk_bubble, cnt_armed, sof_exp;
  logic [3:0] rdy_pat;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = DB'($urandom_range(1, 255));
      b.last = (k == len - 1);
      q_in[p].push_back(b);
      q_ref[p].push_back(b);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_tvalid = '0;
    in_tlast = '0;
    out_tready = 1'b0;
    for (int i = 0; i < N; i++) begin
      q_in[i].delete();
      q_ref[i].delete();
      hs_cnt[i] = 0;
    end
    hold = '0; mid = '0;
    cur = -1; last_served = N - 1; n_out = 0; gap = 0; rdy_ph = 0;
    ord.delete();
    gaps = 0; rnd_rdy = 0; chk_bubble = 0; cnt_armed = 0; sof_exp = 0;
    rdy_pat = 4'b1111;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q_in[i].size() > 0 && (hold[i] || !mid[i] || !gaps || $urandom_range(3) != 0)) begin
        in_tvalid[i] = 1'b1;
        in_tdata[i*DW +: DW] = q_in[i][0].data;
        in_tkeep[i*DB +: DB] = q_in[i][0].keep;
        in_tlast[i] = q_in[i][0].last;
        hold[i] = 1'b1;
      end else begin
        in_tvalid[i] = 1'b0;
        in_tlast[i] = 1'b0;
      end
    end
    out_tready = rnd_rdy ? ($urandom_range(3) != 0) : rdy_pat[rdy_ph % 4];
    rdy_ph++;
`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
    pkt_cnt_clear = '0;
`endif
  endtask

  task automatic sample();
    beat_t e;
    for (int i = 0; i < N; i++)
      if (in_tvalid[i] && in_tready[i]) begin
        mid[i] = !q_in[i][0].last;
        hold[i] = 1'b0;
        void'(q_in[i].pop_front());
        hs_cnt[i]++;
      end
    if (out_tvalid && !out_tready) chk("stall_in_tready", 256'(in_tready), 256'(0));
    if (out_tvalid && out_tready) begin
      if (cur < 0) begin
        for (int k = 1; k <= N; k++)
          if (cur < 0 && q_ref[(last_served + k) % N].size() > 0) cur = (last_served + k) % N;
        if (cur < 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got beat from port %0d expected no beat", out_tuser);
        end else begin
          last_served = cur;
          sof_exp = 1'b1;
          ord.push_back(int'(out_tuser));
          if (chk_bubble && n_out > 0) chk("bubble_cycles", 256'(gap), 256'(1));
        end
      end
      if (cur >= 0) begin
        e = q_ref[cur].pop_front();
        chk("out_beat", 256'({out_tdata, out_tkeep, out_tlast, out_tuser, out_sof}),
            256'({e.data, e.keep, e.last, PW'(cur), sof_exp}));
`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
        if (cnt_armed && cur == 0 && e.last) begin
          pkts_p0++;
          if (pkts_p0 == 4) begin
            chk("pkt_cnt_before_clear", 256'(pkt_cnt[31:0]), 256'(3));
            pkt_cnt_clear[0] = 1'b1;
          end
        end
`endif
        sof_exp = 1'b0;
        n_out++;
        gap = 0;
        if (e.last) cur = -1;
      end
    end else if (!out_tvalid) gap++;
  endtask

  task automatic cycle();
    @(posedge clk); #1; drive();
    @(negedge clk); sample();
  endtask

  function automatic bit busy();
    busy = out_tvalid;
    for (int i = 0; i < N; i++) if (q_ref[i].size() > 0 || q_in[i].size() > 0) busy = 1'b1;
  endfunction

  task automatic run(input string nm, input int max);
    int c = 0;
    while (busy() && c < max) begin cycle(); c++; end
    chk(nm, 256'(busy()), 256'(0));
  endtask

  vec_t tbl[6];
  logic [DW-1:0] d0 = 64'h0123_4567_89ab_cdef, d1 = 64'hfeed_face_cafe_beef, d2 = 64'h5a5a_a5a5_0f0f_f0f0;
  int exp_ord[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    @(negedge clk);
    chk("reset_ctrl", 256'({out_tvalid, in_tready, out_sof}), 256'(0));
    chk("reset_data", 256'({out_tdata, out_tkeep, out_tlast, out_tuser}), 256'(0));
    do_reset();

    // single port 2, one 3-beat packet, cycle by cycle
    tbl[0] = '{1'b1, d0, 1'b0, 1'b1, 1'b0, 4'b0000, 64'h0, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b1, d0, 1'b0, 1'b1, 1'b0, 4'b0100, 64'h0, 1'b0, 1'b0, 5'd0};
    tbl[2] = '{1'b1, d1, 1'b0, 1'b1, 1'b1, 4'b0100, d0, 1'b1, 1'b0, 5'd2};
    tbl[3] = '{1'b1, d2, 1'b1, 1'b1, 1'b1, 4'b0100, d1, 1'b0, 1'b0, 5'd2};
    tbl[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 4'b0000, d2, 1'b0, 1'b1, 5'd2};
    tbl[5] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 64'h0, 1'b0, 1'b0, 5'd0};
    port_enable = 4'b0100;
    in_tkeep = '1;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      in_tvalid = {1'b0, tbl[r].vld, 2'b00};
      in_tdata[2*DW +: DW] = tbl[r].d;
      in_tlast = {1'b0, tbl[r].lst, 2'b00};
      out_tready = tbl[r].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", r), 256'({out_tvalid, in_tready}), 256'({tbl[r].e_ov, tbl[r].e_rdy}));
      if (tbl[r].e_ov)
        chk($sformatf("vec%0d_beat", r), 256'({out_tdata, out_sof, out_tlast, out_tuser}),
            256'({tbl[r].e_d, tbl[r].e_sof, tbl[r].e_lst, tbl[r].e_usr}));
    end

    // round robin over ports 0,1,3 with continuous 2-beat packets
    do_reset();
    port_enable = '1;
    chk_bubble = 1'b1;
    for (int k = 0; k < 2; k++) begin add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2); end
    run("rr_done", 200);
    chk("rr_count", 256'(ord.size()), 256'(6));
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), 256'(k < ord.size() ? ord[k] : -1), 256'(exp_ord[k]));

    // backpressure 1,0,0,1 through a 5-beat packet
    do_reset();
    port_enable = '1;
    rdy_pat = 4'b1001;
    add_pkt(0, 5);
    run("bp_done", 200);
    chk("bp_beats", 256'(n_out), 256'(5));

    // enable drop mid-packet on port 1
    do_reset();
    port_enable = '1;
    add_pkt(1, 4); add_pkt(1, 4);
    for (int c = 0; c < 50 && hs_cnt[1] < 2; c++) cycle();
    chk("en_hs_reached", 256'(hs_cnt[1]), 256'(2));
    port_enable[1] = 1'b0;
    repeat (20) cycle();
    chk("en_beats_out", 256'(n_out), 256'(4));
    chk("en_pending", 256'(q_in[1].size()), 256'(4));
    chk("en_disabled_ready", 256'({out_tvalid, in_tready}), 256'(0));
    port_enable[1] = 1'b1;
    run("en_done", 100);
    chk("en_total", 256'(n_out), 256'(8));

    // asynchronous reset mid-packet
    do_reset();
    port_enable = '1;
    add_pkt(2, 6);
    for (int c = 0; c < 20 && !out_tvalid; c++) cycle();
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("rst_async", 256'({out_tvalid, in_tready, out_sof}), 256'(0));
    do_reset();
    port_enable = '1;
    for (int i = 0; i < N; i++) add_pkt(i, 2);
    run("rst_done", 200);
    chk("rst_first_port", 256'(ord.size() > 0 ? ord[0] : -1), 256'(0));

    // randomized traffic with valid gaps and random backpressure
    for (int s = 0; s < 4; s++) begin
      do_reset();
      port_enable = '1;
      gaps = 1'b1;
      rnd_rdy = 1'b1;
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 4);
        for (int k = 0; k < np; k++) add_pkt(i, $urandom_range(1, 6));
      end
      run($sformatf("rand%0d_done", s), 5000);
    end

`ifdef P4_ROUTER_ING_ARB_PKT_CNT_EN
    do_reset();
    port_enable = '1;
    cnt_armed = 1'b1;
    pkts_p0 = 0;
    for (int k = 0; k < 4; k++) add_pkt(0, 2);
    run("cnt_done", 200);
    cycle();
    chk("pkt_cnt_after_clear", 256'(pkt_cnt[31:0]), 256'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
